config_manager: RTL and testbench
=================================

CONFIG_MANAGER -- requirements
Module: config_manager

Interface
REQ-001 Parameter DEF_BIP_TIME, default 7'd5: bip_time loaded at reset.
REQ-002 Parameter DEF_TRANCA_TIME, default 7'd5: tranca_aut_time loaded at reset.
REQ-003 Parameter DEF_MASTER_PIN, default 16'h1234: master_pin digit1..digit4 (one nibble each, digit1 in MSB nibble) loaded at reset.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 setup_req  input  1  request to enter setup, from lock controller after master PIN accepted; level, sampled only in IDLE.
REQ-007 setup_on  output  1  handshake request to setup block.
REQ-008 setup_end  input  1  handshake reply from setup block; idles high, low = new data valid.
REQ-009 data_setup_old  output  setupPac_t  current configuration offered to setup block.
REQ-010 data_setup_new  input  setupPac_t  edited configuration returned by setup block.
REQ-011 config_out  output  setupPac_t  live configuration for lock logic; same register as data_setup_old.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 update_done  output  1  one-cycle pulse when a new configuration is committed.
REQ-014 update_rejected  output  1  one-cycle pulse when captured configuration is discarded (see Configuration).

Function
REQ-015 FSM states: IDLE, WAIT_END_LOW, WAIT_END_HIGH, DONE.
REQ-016 IDLE: setup_on=0; if setup_req=1 and setup_end=1 -> WAIT_END_LOW, setup_on=1 from the next cycle.
REQ-017 IDLE with setup_req=1 and setup_end=0 (peer not idle): request ignored, remain IDLE.
REQ-018 WAIT_END_LOW: setup_on held 1; data_setup_old/config_out held constant; on setup_end=0 capture data_setup_new into config register at that edge, drop setup_on, -> WAIT_END_HIGH.
REQ-019 Capture excludes master_pin: master_pin field always retains its own register value regardless of data_setup_new.master_pin.
REQ-020 WAIT_END_HIGH: setup_on=0; on setup_end=1 -> DONE.
REQ-021 DONE: single cycle; pulse update_done (or update_rejected, REQ-028); -> IDLE.
REQ-022 Latency: setup_end low sampled at edge N -> config_out new at N+1, setup_on low at N+1; setup_end high sampled at edge M -> pulse at M+1, IDLE at M+2.
REQ-023 setup_req changes outside IDLE are ignored; no request queuing.
REQ-024 No timeout: WAIT_END_LOW and WAIT_END_HIGH wait indefinitely.
REQ-025 update_done and update_rejected never asserted in the same cycle.

Reset
REQ-026 rst=0 at a clock edge, in any state including mid-handshake: state=IDLE, setup_on=0, busy=0, update_done=0, update_rejected=0.
REQ-027 Reset config: bip_status=1, bip_time=DEF_BIP_TIME, tranca_aut_time=DEF_TRANCA_TIME, master_pin status=1 digits=DEF_MASTER_PIN, pin1 status=1 digits 0,0,0,0, pin2..pin4 status=0 digits 0,0,0,0.

Configuration
REQ-028 CONFIG_CHECK_EN defined: capture in WAIT_END_LOW validates data_setup_new: bip_time and tranca_aut_time each within 5..60, every digit of pin1..pin4 <= 9; any violation -> config register unchanged, DONE pulses update_rejected instead of update_done; handshake sequence unchanged.
REQ-029 CONFIG_CHECK_EN undefined: no validation, every capture committed, update_rejected tied 0.

Verification
REQ-030 Reset with rst=0 for 2 cycles -> config_out equals REQ-027 values, setup_on=0, busy=0.
REQ-031 setup_req=1 in IDLE, setup_end=1; later setup_end=0 with data_setup_new.bip_time=30, pin2.status=1, pin2 digits 9,8,7,6; then setup_end=1 -> setup_on 1->0 at capture, config_out.bip_time=30, pin2=9876 enabled, update_done single pulse, busy drops after DONE.
REQ-032 Same as REQ-031 but data_setup_new.master_pin digits 0,0,0,0 -> config_out.master_pin remains 1,2,3,4.
REQ-033 setup_req=1 while setup_end=0 in IDLE -> setup_on stays 0, busy stays 0.
REQ-034 rst=0 during WAIT_END_HIGH after capture of bip_time=30 -> setup_on=0, bip_time back to 5, no update_done pulse.
REQ-035 CONFIG_CHECK_EN defined, capture with tranca_aut_time=61 -> config_out unchanged, update_rejected one pulse, update_done stays 0; undefined -> tranca_aut_time=61 committed, update_done pulses.

Source files
------------

// File: rtl/config_manager.sv
// ---------------------------------------------------------------------------
// config_manager
//
// Owns the lock's live configuration register and runs a four-phase
// handshake with the setup block so a user can edit it:
//   IDLE -> WAIT_END_LOW -> WAIT_END_HIGH -> DONE -> IDLE
// In IDLE, if setup_req is high and the setup block is idle (setup_end high),
// the manager raises setup_on and offers the current configuration on
// data_setup_old. The setup block pulls setup_end low when its edited data is
// valid. The manager captures that data (the master PIN is never overwritten)
// and drops setup_on. When setup_end returns high, it pulses update_done for
// one cycle and goes back to IDLE.
//
// Optional build macro: CONFIG_CHECK_EN
//   When defined, captured data is range-checked before it is committed:
//   bip_time and tranca_aut_time must be 5..60, and every pin1..pin4 digit
//   must be <= 9. Rejected data leaves the register unchanged, and DONE then
//   pulses update_rejected instead of update_done.
//   When undefined, every capture is committed and update_rejected stays 0.
//
// Ports
//   clk             in   single rising-edge clock
//   rst             in   synchronous, active-low reset
//   setup_req       in   request to enter setup; only looked at in IDLE
//   setup_on        out  handshake request to the setup block
//   setup_end       in   handshake reply; idles high, low = new data valid
//   data_setup_old  out  current configuration offered to the setup block
//   data_setup_new  in   edited configuration from the setup block
//   config_out      out  live configuration (same register as data_setup_old)
//   busy            out  high in every state except IDLE
//   update_done     out  one-cycle pulse when a new configuration is committed
//   update_rejected out  one-cycle pulse when captured data is discarded
// ---------------------------------------------------------------------------
package config_manager_pkg;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    typedef struct packed {
        logic       bip_status;
        logic [6:0] bip_time;
        logic [6:0] tranca_aut_time;
        pinPac_t    master_pin;
        pinPac_t    pin1;
        pinPac_t    pin2;
        pinPac_t    pin3;
        pinPac_t    pin4;
    } setupPac_t;

endpackage

module config_manager
    import config_manager_pkg::*;
#(
    parameter logic [6:0]  DEF_BIP_TIME    = 7'd5,
    parameter logic [6:0]  DEF_TRANCA_TIME = 7'd5,
    parameter logic [15:0] DEF_MASTER_PIN  = 16'h1234
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      setup_req,
    output logic      setup_on,
    input  logic      setup_end,
    output setupPac_t data_setup_old,
    input  setupPac_t data_setup_new,
    output setupPac_t config_out,
    output logic      busy,
    output logic      update_done,
    output logic      update_rejected
);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        WAIT_END_LOW  = 2'd1,
        WAIT_END_HIGH = 2'd2,
        DONE          = 2'd3
    } state_t;

    state_t    state_q, state_d;
    setupPac_t cfg_q, cfg_d;
    logic      setup_on_q, setup_on_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      rej_q, rej_d;
    // Remembers, from capture until DONE, whether the captured data was discarded.
    logic      reject_flag_q, reject_flag_d;

    setupPac_t merged;
    logic      cap_ok;

    function automatic setupPac_t reset_config();
        setupPac_t c;
        c                   = '0;
        c.bip_status        = 1'b1;
        c.bip_time          = DEF_BIP_TIME;
        c.tranca_aut_time   = DEF_TRANCA_TIME;
        c.master_pin.status = 1'b1;
        c.master_pin.digit1 = DEF_MASTER_PIN[15:12];
        c.master_pin.digit2 = DEF_MASTER_PIN[11:8];
        c.master_pin.digit3 = DEF_MASTER_PIN[7:4];
        c.master_pin.digit4 = DEF_MASTER_PIN[3:0];
        c.pin1.status       = 1'b1;
        return c;
    endfunction

`ifdef CONFIG_CHECK_EN
    function automatic logic time_ok(input logic [6:0] t);
        return (t >= 7'd5) && (t <= 7'd60);
    endfunction

    function automatic logic digits_ok(input pinPac_t p);
        return (p.digit1 <= 4'd9) && (p.digit2 <= 4'd9) &&
               (p.digit3 <= 4'd9) && (p.digit4 <= 4'd9);
    endfunction

    function automatic logic config_valid(input setupPac_t c);
        return time_ok(c.bip_time) && time_ok(c.tranca_aut_time) &&
               digits_ok(c.pin1) && digits_ok(c.pin2) &&
               digits_ok(c.pin3) && digits_ok(c.pin4);
    endfunction
`endif

    // The master PIN is never taken from the setup block.
    always_comb begin
        merged            = data_setup_new;
        merged.master_pin = cfg_q.master_pin;
    end

`ifdef CONFIG_CHECK_EN
    assign cap_ok = config_valid(merged);
`else
    assign cap_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        cfg_d         = cfg_q;
        setup_on_d    = 1'b0;
        done_d        = 1'b0;
        rej_d         = 1'b0;
        reject_flag_d = reject_flag_q;

        case (state_q)
            IDLE: begin
                // Start only if the setup block is idle; otherwise drop the request.
                if (setup_req && setup_end) begin
                    state_d    = WAIT_END_LOW;
                    setup_on_d = 1'b1;
                end
            end
            WAIT_END_LOW: begin
                setup_on_d = 1'b1;
                if (!setup_end) begin
                    setup_on_d    = 1'b0;
                    state_d       = WAIT_END_HIGH;
                    reject_flag_d = !cap_ok;
                    if (cap_ok) begin
                        cfg_d = merged;
                    end
                end
            end
            WAIT_END_HIGH: begin
                if (setup_end) begin
                    state_d = DONE;
                    done_d  = !reject_flag_q;
                    rej_d   = reject_flag_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cfg_q         <= reset_config();
            setup_on_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rej_q         <= 1'b0;
            reject_flag_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            setup_on_q    <= setup_on_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rej_q         <= rej_d;
            reject_flag_q <= reject_flag_d;
        end
    end

    assign setup_on        = setup_on_q;
    assign busy            = busy_q;
    assign update_done     = done_q;
    assign data_setup_old  = cfg_q;
    assign config_out      = cfg_q;
`ifdef CONFIG_CHECK_EN
    assign update_rejected = rej_q;
`else
    // Without checking nothing is ever discarded; rej_q stays 0 in this build.
    assign update_rejected = rej_q & 1'b0;
`endif

endmodule

// File: tb/tb_config_manager.sv
// Testbench for config_manager: table-driven handshakes, randomized handshakes
// against a behavioural model, and hand-written reset and ignored-request cases.
module tb_config_manager;
    import config_manager_pkg::*;

`ifdef CONFIG_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst;
    logic      setup_req;
    logic      setup_on;
    logic      setup_end;
    setupPac_t data_setup_old;
    setupPac_t data_setup_new;
    setupPac_t config_out;
    logic      busy;
    logic      update_done;
    logic      update_rejected;

    int n_chk  = 0;
    int n_fail = 0;

    setupPac_t exp_cfg;

    config_manager dut (
        .clk            (clk),
        .rst            (rst),
        .setup_req      (setup_req),
        .setup_on       (setup_on),
        .setup_end      (setup_end),
        .data_setup_old (data_setup_old),
        .data_setup_new (data_setup_new),
        .config_out     (config_out),
        .busy           (busy),
        .update_done    (update_done),
        .update_rejected(update_rejected)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_cfg(input string nm, input setupPac_t act, input setupPac_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic setupPac_t model_reset_cfg();
        setupPac_t c;
        c = '0;
        c.bip_status = 1'b1;
        c.bip_time = 7'd5;
        c.tranca_aut_time = 7'd5;
        c.master_pin = {1'b1, 16'h1234};
        c.pin1.status = 1'b1;
        return c;
    endfunction

    function automatic bit model_valid(input setupPac_t c);
        int bt, tt;
        logic [15:0] pins [4];
        bt = int'(c.bip_time);
        tt = int'(c.tranca_aut_time);
        if (bt < 5 || bt > 60 || tt < 5 || tt > 60) return 1'b0;
        pins[0] = {c.pin1.digit1, c.pin1.digit2, c.pin1.digit3, c.pin1.digit4};
        pins[1] = {c.pin2.digit1, c.pin2.digit2, c.pin2.digit3, c.pin2.digit4};
        pins[2] = {c.pin3.digit1, c.pin3.digit2, c.pin3.digit3, c.pin3.digit4};
        pins[3] = {c.pin4.digit1, c.pin4.digit2, c.pin4.digit3, c.pin4.digit4};
        for (int p = 0; p < 4; p++)
            for (int d = 0; d < 4; d++)
                if (((int'(pins[p]) >> (4 * d)) % 16) > 9) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- sequences ----------------
    task automatic do_reset();
        rst = 1'b0;
        setup_req = 1'b0;
        setup_end = 1'b1;
        step();
        step();
        rst = 1'b1;
        exp_cfg = model_reset_cfg();
        chk_cfg("reset_config", config_out, exp_cfg);
        chk_cfg("reset_old", data_setup_old, exp_cfg);
        chk_bit("reset_setup_on", setup_on, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_done", update_done, 1'b0);
        chk_bit("reset_rej", update_rejected, 1'b0);
    endtask

    // Full handshake delivering nd. Returns whether the model expects a commit.
    task automatic do_update(input setupPac_t nd, input int wl, input int wh, output bit committed);
        bit ok;
        setup_req = 1'b1;
        setup_end = 1'b1;
        step();
        setup_req = 1'b0;
        chk_bit("start_setup_on", setup_on, 1'b1);
        chk_bit("start_busy", busy, 1'b1);
        for (int i = 0; i < wl; i++) begin
            setup_req = 1'($urandom_range(0, 1));
            data_setup_new = nd;
            step();
            chk_bit("wlow_setup_on", setup_on, 1'b1);
            chk_cfg("wlow_hold", config_out, exp_cfg);
        end
        setup_req = 1'b0;
        data_setup_new = nd;
        setup_end = 1'b0;
        step();
        ok = !CHECK_EN || model_valid(nd);
        if (ok) begin
            exp_cfg = nd;
            exp_cfg.master_pin = {1'b1, 16'h1234};
        end
        committed = ok;
        chk_bit("cap_setup_on", setup_on, 1'b0);
        chk_cfg("cap_config", config_out, exp_cfg);
        chk_bit("cap_busy", busy, 1'b1);
        data_setup_new = '0;
        for (int i = 0; i < wh; i++) begin
            setup_req = 1'($urandom_range(0, 1));
            step();
            chk_bit("whigh_setup_on", setup_on, 1'b0);
            chk_bit("whigh_done", update_done, 1'b0);
        end
        setup_req = 1'b0;
        setup_end = 1'b1;
        step();
        chk_bit("done_pulse", update_done, ok);
        chk_bit("rej_pulse", update_rejected, !ok);
        chk_bit("done_busy", busy, 1'b1);
        step();
        chk_bit("idle_done", update_done, 1'b0);
        chk_bit("idle_rej", update_rejected, 1'b0);
        chk_bit("idle_busy", busy, 1'b0);
        chk_bit("idle_setup_on", setup_on, 1'b0);
        chk_cfg("idle_config", config_out, exp_cfg);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        setupPac_t  din;
        logic [6:0] exp_bip;
        logic [6:0] exp_tr;
    } vec_t;

    vec_t tbl [8];

    function automatic setupPac_t mk(input logic [6:0] bt, input logic [6:0] tt);
        setupPac_t c;
        c = model_reset_cfg();
        c.bip_time = bt;
        c.tranca_aut_time = tt;
        c.pin2 = {1'b1, 4'd9, 4'd8, 4'd7, 4'd6};
        return c;
    endfunction

    initial begin
        bit cm;
        setupPac_t r;
        rst = 1'b0;
        setup_req = 1'b0;
        setup_end = 1'b1;
        data_setup_new = '0;

        // Table: {input configuration, expected bip_time/tranca_aut_time after}
        tbl[0].din = mk(7'd30, 7'd20);
        tbl[0].exp_bip = 7'd30; tbl[0].exp_tr = 7'd20;
        tbl[1].din = mk(7'd30, 7'd20);
        tbl[1].din.master_pin = '0;
        tbl[1].exp_bip = 7'd30; tbl[1].exp_tr = 7'd20;
        tbl[2].din = mk(7'd30, 7'd61);
        tbl[2].exp_bip = 7'd30; tbl[2].exp_tr = CHECK_EN ? 7'd20 : 7'd61;
        tbl[3].din = mk(7'd60, 7'd5);
        tbl[3].exp_bip = 7'd60; tbl[3].exp_tr = 7'd5;
        tbl[4].din = mk(7'd4, 7'd5);
        tbl[4].exp_bip = CHECK_EN ? 7'd60 : 7'd4; tbl[4].exp_tr = 7'd5;
        tbl[5].din = mk(7'd5, 7'd60);
        tbl[5].din.pin3.digit1 = 4'd10;
        tbl[5].exp_bip = CHECK_EN ? 7'd60 : 7'd5; tbl[5].exp_tr = CHECK_EN ? 7'd5 : 7'd60;
        tbl[6].din = mk(7'd5, 7'd60);
        tbl[6].din.pin4 = {1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
        tbl[6].exp_bip = 7'd5; tbl[6].exp_tr = 7'd60;
        tbl[7].din = mk(7'd61, 7'd30);
        tbl[7].exp_bip = CHECK_EN ? 7'd5 : 7'd61; tbl[7].exp_tr = CHECK_EN ? 7'd60 : 7'd30;

        do_reset();

        // Request while the setup block is busy must be dropped.
        setup_end = 1'b0;
        setup_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_bit("ignored_setup_on", setup_on, 1'b0);
            chk_bit("ignored_busy", busy, 1'b0);
        end
        setup_req = 1'b0;
        setup_end = 1'b1;
        step();
        chk_bit("ignored_after", busy, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_update(tbl[i].din, i % 3, (i + 1) % 3, cm);
            chk_bit("tbl_bip", config_out.bip_time == tbl[i].exp_bip, 1'b1);
            chk_bit("tbl_tranca", config_out.tranca_aut_time == tbl[i].exp_tr, 1'b1);
            chk_bit("tbl_master", config_out.master_pin == {1'b1, 16'h1234}, 1'b1);
            if (i == 0)
                chk_bit("tbl_pin2", config_out.pin2 == {1'b1, 16'h9876}, 1'b1);
        end

        // Randomized handshakes against the model.
        for (int n = 0; n < 30; n++) begin
            r = setupPac_t'({$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 3) != 0) begin
                r.bip_time = 7'($urandom_range(5, 60));
                r.tranca_aut_time = 7'($urandom_range(5, 60));
                r.pin1 = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                r.pin2 = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                r.pin3 = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                r.pin4 = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            do_update(r, $urandom_range(0, 3), $urandom_range(0, 3), cm);
        end

        // Reset during WAIT_END_HIGH after a valid capture of bip_time=30.
        do_reset();
        setup_req = 1'b1;
        setup_end = 1'b1;
        step();
        setup_req = 1'b0;
        data_setup_new = mk(7'd30, 7'd20);
        setup_end = 1'b0;
        step();
        chk_bit("midrst_captured", config_out.bip_time == 7'd30, 1'b1);
        rst = 1'b0;
        step();
        chk_bit("midrst_setup_on", setup_on, 1'b0);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_cfg("midrst_config", config_out, model_reset_cfg());
        chk_bit("midrst_done", update_done, 1'b0);
        rst = 1'b1;
        setup_end = 1'b1;
        step();
        chk_bit("midrst_no_pulse", update_done, 1'b0);
        chk_bit("midrst_no_rej", update_rejected, 1'b0);
        step();
        chk_bit("midrst_no_pulse2", update_done, 1'b0);
        chk_bit("midrst_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
